// File: rtl/c6288_pkg.sv
// c6288_pkg: shared widths and datatypes for the registered 16x16 unsigned
// array multiplier (ISCAS-85 c6288 function).
//   OP_W   operand width (16)
//   PROD_W product width (32)
//   op_t   operand word, prod_t product word
package c6288_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/c6288_multiplier_if.sv
// c6288_multiplier_if: operand/product bundle between the register shell and
// the combinational array core.
//   a, b : operands (driven by master)
//   p    : full product (driven by slave, the core)
interface c6288_multiplier_if;
    import c6288_pkg::*;

    op_t   a;
    op_t   b;
    prod_t p;

    modport master (output a, output b, input p);
    modport slave  (input a, input b, output p);

endinterface

// File: rtl/c6288_array_core.sv
// c6288_array_core: purely combinational 16x16 unsigned carry-save array
// multiplier, p = a * b built from half/full-adder equations.
//   bus.slave : a, b in; p out (full 32-bit product)
// Row i holds sum bits s[j] at weight i+j and carries c[j] at weight i+j+1.
// Each row adds partial products a[j]&b[i] to the previous row's shifted sums
// and carries; the last row's sums/carries are merged by a ripple adder into
// p[31:16].
module c6288_array_core
    import c6288_pkg::*;
(
    c6288_multiplier_if.slave bus
);

    genvar i, j;

    for (i = 0; i < OP_W; i++) begin : g_row
        logic [OP_W-1:0] s;
        logic [OP_W-1:0] c;

        if (i == 0) begin : g_init
            assign s = bus.a & {OP_W{bus.b[0]}};
            assign c = '0;
        end else begin : g_csa
            for (j = 0; j < OP_W; j++) begin : g_cell
                logic x, z;
                assign x = bus.a[j] & bus.b[i];
                assign z = g_row[i-1].c[j];
                if (j < OP_W - 1) begin : g_fa
                    logic y;
                    assign y    = g_row[i-1].s[j+1];
                    assign s[j] = x ^ y ^ z;
                    assign c[j] = (x & y) | (z & (x ^ y));
                end else begin : g_ha
                    // top column has no shifted-in sum: half adder
                    assign s[j] = x ^ z;
                    assign c[j] = x & z;
                end
            end
        end

        assign bus.p[i] = s[0];
    end

    // Final ripple-carry row producing p[31:16].
    for (j = 0; j < OP_W; j++) begin : g_fin
        if (j == 0) begin : g_add
            logic x, y, co;
            assign x              = g_row[OP_W-1].s[j+1];
            assign y              = g_row[OP_W-1].c[j];
            assign bus.p[OP_W+j]  = x ^ y;
            assign co             = x & y;
        end else if (j < OP_W - 1) begin : g_add
            logic x, y, ci, co;
            assign x              = g_row[OP_W-1].s[j+1];
            assign y              = g_row[OP_W-1].c[j];
            assign ci             = g_fin[j-1].g_add.co;
            assign bus.p[OP_W+j]  = x ^ y ^ ci;
            assign co             = (x & y) | (ci & (x ^ y));
        end else begin : g_msb
            // carry out of the MSB is always zero for a 16x16 product
            assign bus.p[OP_W+j] = g_row[OP_W-1].c[j] ^ g_fin[j-1].g_add.co;
        end
    end

endmodule

// File: rtl/c6288_multiplier.sv
// c6288_multiplier: registered 16x16 unsigned multiplier with c6288 pin names.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the product register
//   N1..N256   operand A bits 0..15
//   N273..N528 operand B bits 0..15
//   N545..N6288 product P bits 0..31, registered (1-cycle latency)
module c6288_multiplier
    import c6288_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic N1, N18, N35, N52, N69, N86, N103, N120,
    input  logic N137, N154, N171, N188, N205, N222, N239, N256,
    input  logic N273, N290, N307, N324, N341, N358, N375, N392,
    input  logic N409, N426, N443, N460, N477, N494, N511, N528,
    output logic N545, N1581, N1901, N2223, N2548, N2877, N3211, N3552,
    output logic N3895, N4241, N4591, N4946, N5308, N5672, N5971, N6123,
    output logic N6150, N6160, N6170, N6180, N6190, N6200, N6210, N6220,
    output logic N6230, N6240, N6250, N6260, N6270, N6280, N6287, N6288
);

    c6288_multiplier_if core_if ();

    prod_t prod_q;

    assign core_if.a = {N256, N239, N222, N205, N188, N171, N154, N137,
                        N120, N103, N86,  N69,  N52,  N35,  N18,  N1};
    assign core_if.b = {N528, N511, N494, N477, N460, N443, N426, N409,
                        N392, N375, N358, N341, N324, N307, N290, N273};

    c6288_array_core u_core (.bus(core_if.slave));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod_q <= '0;
        else        prod_q <= core_if.p;
    end

    assign {N6288, N6287, N6280, N6270, N6260, N6250, N6240, N6230,
            N6220, N6210, N6200, N6190, N6180, N6170, N6160, N6150,
            N6123, N5971, N5672, N5308, N4946, N4591, N4241, N3895,
            N3552, N3211, N2877, N2548, N2223, N1901, N1581, N545} = prod_q;

endmodule

// File: tb/tb_c6288_multiplier.sv
// tb_c6288_multiplier: self-checking bench for c6288_multiplier.
// Table-driven vectors plus reset sequences and a random regression, with a
// scoreboard queue of expected products popped one edge after each apply.
module tb_c6288_multiplier;
    import c6288_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] vec = '0;

    int checks = 0;
    int failures = 0;
    prod_t exp_q[$];

    typedef struct {
        op_t   a;
        op_t   b;
        prod_t p;
    } vec_t;

    vec_t tbl[6];

    c6288_multiplier_if tb_if ();

    always #5 clk = ~clk;

    function automatic op_t rev16(input op_t v);
        op_t r;
        for (int k = 0; k < 16; k++) r[k] = v[15-k];
        return r;
    endfunction

    logic N545, N1581, N1901, N2223, N2548, N2877, N3211, N3552;
    logic N3895, N4241, N4591, N4946, N5308, N5672, N5971, N6123;
    logic N6150, N6160, N6170, N6180, N6190, N6200, N6210, N6220;
    logic N6230, N6240, N6250, N6260, N6270, N6280, N6287, N6288;

    // packed word: bit 31 -> N1 (A[0]), bit 0 -> N528 (B[15])
    assign tb_if.a = rev16(vec[31:16]);
    assign tb_if.b = rev16(vec[15:0]);
    assign tb_if.p = {N6288, N6287, N6280, N6270, N6260, N6250, N6240, N6230,
                      N6220, N6210, N6200, N6190, N6180, N6170, N6160, N6150,
                      N6123, N5971, N5672, N5308, N4946, N4591, N4241, N3895,
                      N3552, N3211, N2877, N2548, N2223, N1901, N1581, N545};

    c6288_multiplier dut (
        .clk(clk), .rst_n(rst_n),
        .N1(vec[31]),   .N18(vec[30]),  .N35(vec[29]),  .N52(vec[28]),
        .N69(vec[27]),  .N86(vec[26]),  .N103(vec[25]), .N120(vec[24]),
        .N137(vec[23]), .N154(vec[22]), .N171(vec[21]), .N188(vec[20]),
        .N205(vec[19]), .N222(vec[18]), .N239(vec[17]), .N256(vec[16]),
        .N273(vec[15]), .N290(vec[14]), .N307(vec[13]), .N324(vec[12]),
        .N341(vec[11]), .N358(vec[10]), .N375(vec[9]),  .N392(vec[8]),
        .N409(vec[7]),  .N426(vec[6]),  .N443(vec[5]),  .N460(vec[4]),
        .N477(vec[3]),  .N494(vec[2]),  .N511(vec[1]),  .N528(vec[0]),
        .N545(N545),   .N1581(N1581), .N1901(N1901), .N2223(N2223),
        .N2548(N2548), .N2877(N2877), .N3211(N3211), .N3552(N3552),
        .N3895(N3895), .N4241(N4241), .N4591(N4591), .N4946(N4946),
        .N5308(N5308), .N5672(N5672), .N5971(N5971), .N6123(N6123),
        .N6150(N6150), .N6160(N6160), .N6170(N6170), .N6180(N6180),
        .N6190(N6190), .N6200(N6200), .N6210(N6210), .N6220(N6220),
        .N6230(N6230), .N6240(N6240), .N6250(N6250), .N6260(N6260),
        .N6270(N6270), .N6280(N6280), .N6287(N6287), .N6288(N6288)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic set_ops(input op_t a, input op_t b);
        vec = {rev16(a), rev16(b)};
    endtask

    // drive operands and push the product they must produce after the next edge
    task automatic apply(input op_t a, input op_t b, input prod_t p);
        set_ops(a, b);
        exp_q.push_back(p);
    endtask

    // advance one edge, then compare the oldest outstanding expectation
    task automatic step(input string name);
        prod_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(name, tb_if.p, e);
        end
    endtask

    initial begin
        tbl[0] = '{a: 16'h0000, b: 16'hFFFF, p: 32'h00000000};
        tbl[1] = '{a: 16'h0001, b: 16'hBEEF, p: 32'h0000BEEF};
        tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001};
        tbl[3] = '{a: 16'h8000, b: 16'h0002, p: 32'h00010000};
        tbl[4] = '{a: 16'h00FF, b: 16'h0100, p: 32'h0000FF00};
        tbl[5] = '{a: 16'h1234, b: 16'h5678, p: 32'h06260060};

        // reset held with all-ones operands while the clock runs
        set_ops(16'hFFFF, 16'hFFFF);
        #2;
        check("reset_async", tb_if.p, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", tb_if.p, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'hFFFE0001);
        step("reset_release");

        // table vectors, one per cycle
        for (int k = 0; k < 6; k++) begin
            apply(tbl[k].a, tbl[k].b, tbl[k].p);
            step($sformatf("tbl_%0d", k));
        end

        // per-bit mapping on the 0x1234*0x5678 result now on the outputs
        check("bit_N545", {31'b0, N545}, 32'h0);
        check("bit_N6288", {31'b0, N6288}, 32'h0);
        check("bit_N2877", {31'b0, N2877}, 32'h1);

        // mid-stream reset pulse between edges, operands held
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", tb_if.p, 32'h0);
        @(posedge clk);
        #1;
        check("midreset_edge_ignored", tb_if.p, 32'h0);
        #3;
        rst_n = 1'b1;
        exp_q.push_back(32'h06260060);
        step("midreset_restore");

        // random regression: packed words, expected from bit-reversed A x B
        for (int k = 0; k < 31; k++) begin
            logic [31:0] w;
            prod_t e;
            w = $urandom;
            e = 32'(rev16(w[31:16])) * 32'(rev16(w[15:0]));
            vec = w;
            exp_q.push_back(e);
            step($sformatf("rand_%0d", k));
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
